// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage access unit and its MEM/WB register.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_TIMEOUT = 255;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Counter must be able to hold TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register with load enable and bubble insertion (bubble clears reg_write only).
module mem_wb_register
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              bubble,
    input  logic [DATA_W-1:0] new_write_data,
    input  logic [REG_W-1:0]  new_write_reg,
    input  logic              new_reg_write,
    input  logic              new_mem_to_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [REG_W-1:0]  write_reg,
    output logic              reg_write,
    output logic              mem_to_reg
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_data <= '0;
            write_reg  <= '0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
        end else if (bubble) begin
            reg_write <= 1'b0;
        end else if (load_en) begin
            write_data <= new_write_data;
            write_reg  <= new_write_reg;
            reg_write  <= new_reg_write;
            mem_to_reg <= new_mem_to_reg;
        end
    end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM stage: runs the data-memory req/ack transaction for EX/MEM and feeds MEM/WB.
module mem_stage_access_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] exmem_pc,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic [DATA_W-1:0] exmem_read_data2,
    input  logic [REG_W-1:0]  exmem_write_reg,
    input  logic              exmem_jal,
    input  logic              exmem_mem_read,
    input  logic              exmem_mem_to_reg,
    input  logic              exmem_mem_write,
    input  logic              exmem_reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] memwb_write_data,
    output logic [REG_W-1:0]  memwb_write_reg,
    output logic              memwb_reg_write,
    output logic              memwb_mem_to_reg,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int                CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ADDR_MASK = ~(DATA_W'(WORD_ALIGN_MASK));

    mem_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              abort;
    logic [DATA_W-1:0] rdata_q;

    logic access, aligned;
    logic stall_c, start, misalign, ack_hit, timeout_hit, finish;
    logic [DATA_W-1:0] wb_data;
    logic              wb_reg_write;

    assign access  = exmem_mem_read | exmem_mem_write;
    assign aligned = (exmem_alu_result[1:0] & WORD_ALIGN_MASK) == 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        stall_c     = 1'b0;
        start       = 1'b0;
        misalign    = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    stall_c    = 1'b1;
                    start      = 1'b1;
                    state_next = BUSY;
                end else if (access) begin
                    misalign = 1'b1;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                // ack takes priority over a coincident timeout
                if (dmem_ack) begin
                    ack_hit    = 1'b1;
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign mem_stall = reset & stall_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            abort        <= 1'b0;
            rdata_q      <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= misalign;
            bus_err      <= finish & abort;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= exmem_mem_write;
                dmem_addr  <= exmem_alu_result & ADDR_MASK;
                dmem_wdata <= exmem_read_data2;
                abort      <= 1'b0;
                cnt        <= '0;
            end
            if (state == BUSY) cnt <= cnt + 1'b1;
            if (ack_hit) begin
                dmem_req <= 1'b0;
                rdata_q  <= dmem_rdata;
            end
            if (timeout_hit) begin
                dmem_req <= 1'b0;
                abort    <= 1'b1;
            end
            if (finish) begin
                cnt   <= '0;
                abort <= 1'b0;
            end
        end
    end

    assign wb_data      = exmem_jal ? exmem_pc : (exmem_mem_to_reg ? rdata_q : exmem_alu_result);
    assign wb_reg_write = exmem_reg_write & ~(misalign | (finish & abort));

    mem_wb_register #(
        .DATA_W(DATA_W),
        .REG_W (REG_W)
    ) u_mem_wb (
        .clk           (clk),
        .reset         (reset),
        .load_en       (~stall_c),
        .bubble        (stall_c),
        .new_write_data(wb_data),
        .new_write_reg (exmem_write_reg),
        .new_reg_write (wb_reg_write),
        .new_mem_to_reg(exmem_mem_to_reg),
        .write_data    (memwb_write_data),
        .write_reg     (memwb_write_reg),
        .reg_write     (memwb_reg_write),
        .mem_to_reg    (memwb_mem_to_reg)
    );

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Scoreboard bench for mem_stage_access_unit: directed plan cases plus random instructions vs a memory model.
module tb_mem_stage_access_unit;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int TMO   = 4;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] exmem_pc = '0, exmem_alu_result = '0, exmem_read_data2 = '0;
    logic [RW-1:0] exmem_write_reg = '0;
    logic          exmem_jal = 1'b0, exmem_mem_read = 1'b0, exmem_mem_to_reg = 1'b0;
    logic          exmem_mem_write = 1'b0, exmem_reg_write = 1'b0;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ack = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          mem_stall;
    logic [DW-1:0] memwb_write_data;
    logic [RW-1:0] memwb_write_reg;
    logic          memwb_reg_write, memwb_mem_to_reg, misalign_err, bus_err;

    mem_stage_access_unit #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .exmem_pc(exmem_pc), .exmem_alu_result(exmem_alu_result),
        .exmem_read_data2(exmem_read_data2), .exmem_write_reg(exmem_write_reg),
        .exmem_jal(exmem_jal), .exmem_mem_read(exmem_mem_read),
        .exmem_mem_to_reg(exmem_mem_to_reg), .exmem_mem_write(exmem_mem_write),
        .exmem_reg_write(exmem_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .memwb_write_data(memwb_write_data),
        .memwb_write_reg(memwb_write_reg), .memwb_reg_write(memwb_reg_write),
        .memwb_mem_to_reg(memwb_mem_to_reg), .misalign_err(misalign_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rw;
        logic [RW-1:0] wr;
        logic          m2r;
        logic [DW-1:0] data;
        logic          mis;
        logic          berr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b1;
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] bus_mem[logic [31:0]];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'hC3A5_9617;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : mem_init(a);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctl"}, 32'({dmem_req, dmem_we, mem_stall, memwb_reg_write,
                                  memwb_mem_to_reg, misalign_err, bus_err}), 32'h0);
        check({tag, " dmem_addr"}, dmem_addr, 32'h0);
        check({tag, " dmem_wdata"}, dmem_wdata, 32'h0);
        check({tag, " wb_data"}, memwb_write_data, 32'h0);
        check({tag, " wb_reg"}, 32'(memwb_write_reg), 32'h0);
    endtask

    // One instruction: drive EX/MEM, predict MEM/WB, act as the bus slave until it leaves MEM.
    task automatic run_instr(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                             input logic [31:0] wdata, input logic [4:0] wr, input logic jal,
                             input logic rd, input logic m2r, input logic wrt, input logic rw,
                             input int wait_n);
        exp_t e;
        logic acc, ok;
        int   busy_n, st_n, rq, sc, cyc;
        bit   done;
        exmem_pc = pc; exmem_alu_result = alu; exmem_read_data2 = wdata;
        exmem_write_reg = wr; exmem_jal = jal; exmem_mem_read = rd;
        exmem_mem_to_reg = m2r; exmem_mem_write = wrt; exmem_reg_write = rw;
        e = '0;
        e.wr = wr; e.m2r = m2r; e.rw = rw;
        e.data = jal ? pc : alu;
        acc = rd | wrt;
        busy_n = 0;
        if (acc && alu[1:0] != 2'b00) begin
            e.rw = 1'b0;
            e.mis = 1'b1;
        end else if (acc) begin
            busy_n = (wait_n + 1 < TMO) ? wait_n + 1 : TMO;
            ok = (wait_n < TMO);
            e.rw = rw & ok;
            e.berr = ~ok;
            if (m2r) e.data = model_rd(alu);
            if (wrt && ok) model_mem[alu] = wdata;
        end
        st_n = (acc && !e.mis) ? busy_n + 1 : 0;
        exp_q.push_back(e);

        rq = 0; sc = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            dmem_ack = 1'b0;
            if (dmem_req) begin
                rq++;
                check({tag, " dmem_addr"}, dmem_addr, alu);
                check({tag, " dmem_we"}, 32'(dmem_we), 32'(wrt));
                if (wrt) check({tag, " dmem_wdata"}, dmem_wdata, wdata);
                if (rq == wait_n + 1) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) begin
                        bus_mem[dmem_addr] = dmem_wdata;
                        dmem_rdata = $urandom;
                    end else begin
                        dmem_rdata = bus_mem.exists(dmem_addr) ? bus_mem[dmem_addr] : mem_init(dmem_addr);
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dmem_ack = 1'b1;
                dmem_rdata = $urandom;
            end
            if (mem_stall) sc++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        dmem_ack = 1'b0;
        check({tag, " completes"}, 32'(done), 32'h1);
        check({tag, " stall cycles"}, 32'(sc), 32'(st_n));
        check({tag, " req cycles"}, 32'(rq), 32'(busy_n));
    endtask

    // Monitor: every unstalled edge out of reset presents one MEM/WB entry.
    initial begin
        logic s, r;
        exp_t e;
        forever begin
            @(negedge clk);
            s = mem_stall;
            r = reset;
            @(posedge clk);
            #1;
            if (!mon_en || !r || !reset) continue;
            if (s) begin
                check("bubble reg_write", 32'(memwb_reg_write), 32'h0);
                check("bubble err flags", 32'({misalign_err, bus_err}), 32'h0);
            end else begin
                check("scoreboard has entry", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wb reg_write", 32'(memwb_reg_write), 32'(e.rw));
                    check("wb write_reg", 32'(memwb_write_reg), 32'(e.wr));
                    check("wb mem_to_reg", 32'(memwb_mem_to_reg), 32'(e.m2r));
                    check("misalign_err", 32'(misalign_err), 32'(e.mis));
                    check("bus_err", 32'(bus_err), 32'(e.berr));
                    if (e.rw) check("wb write_data", memwb_write_data, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind, cyc;
        logic [31:0] addr;
        model_mem[32'h100] = 32'hDEAD_BEEF;
        bus_mem[32'h100]   = 32'hDEAD_BEEF;

        // Aligned load presented during reset: stall must still read 0.
        exmem_alu_result = 32'h100; exmem_mem_read = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr("load",     32'h0,  32'h100, 32'h0,        5'd8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        run_instr("store",    32'h0,  32'h200, 32'h12345678, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        run_instr("misalign", 32'h0,  32'h102, 32'h0,        5'd9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        run_instr("timeout",  32'h0,  32'h300, 32'h0,        5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, NEVER);
        run_instr("alu",      32'h0,  32'h7,   32'h0,        5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_instr("jal",      32'h40, 32'h99,  32'h0,        5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_instr("reload",   32'h0,  32'h200, 32'h0,        5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        run_instr("rd+wr",    32'h0,  32'h204, 32'hCAFEF00D, 5'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 5);
            addr = 32'h300 + 32'($urandom_range(0, 15)) * 4;
            case (kind)
                0: run_instr("rnd alu", $urandom, $urandom, $urandom, 5'($urandom),
                             1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), 0);
                1: run_instr("rnd jal", $urandom, $urandom, $urandom, 5'($urandom),
                             1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom), 0);
                2: run_instr("rnd load", $urandom, addr, $urandom, 5'($urandom),
                             1'b0, 1'b1, 1'b1, 1'b0, 1'($urandom), $urandom_range(0, 5));
                3: run_instr("rnd store", $urandom, addr, $urandom, 5'($urandom),
                             1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom), $urandom_range(0, 5));
                4: run_instr("rnd misalign", $urandom, addr | 32'($urandom_range(1, 3)), $urandom,
                             5'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b1, 0);
                default: run_instr("rnd rd+wr", $urandom, addr, $urandom, 5'($urandom),
                             1'b0, 1'b1, 1'b0, 1'b1, 1'($urandom), $urandom_range(0, 5));
            endcase
        end

        // Reset in the middle of a BUSY transaction that would never be acked.
        exmem_alu_result = 32'h100; exmem_mem_read = 1'b1; exmem_mem_write = 1'b0;
        exmem_mem_to_reg = 1'b1; exmem_reg_write = 1'b1; exmem_jal = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!dmem_req && cyc < 10);
        check("mid-busy req seen", 32'(dmem_req), 32'h1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("mid-busy reset");
        exmem_mem_read = 1'b0; exmem_mem_to_reg = 1'b0; exmem_reg_write = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr("post-reset alu",  32'h0, 32'h55,  32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_instr("post-reset load", 32'h0, 32'h200, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2);

        @(negedge clk);
        mon_en = 1'b0;
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- Consumer end of the EX/MEM pipeline register: takes EX/MEM outputs, runs the data-memory transaction over a req/ack bus, and registers results into MEM/WB.
- Asserts mem_stall while a load/store is outstanding, so upstream pipeline registers hold.
- Squashes writeback on misaligned access or bus timeout.

Parameters:
- DATA_W, 32, data/address width
- REG_W, 5, register-index width
- TIMEOUT, 255, max BUSY cycles without dmem_ack before abort (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- exmem_pc  in  DATA_W  PC from EX/MEM (value written on jal)
- exmem_alu_result  in  DATA_W  ALU result / memory address
- exmem_read_data2  in  DATA_W  store data
- exmem_write_reg  in  REG_W  destination register
- exmem_jal, exmem_mem_read, exmem_mem_to_reg, exmem_mem_write, exmem_reg_write  in  1 each  control
- dmem_req  out  1  registered request
- dmem_we  out  1  1=write
- dmem_addr  out  DATA_W  word-aligned address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  transaction complete
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- mem_stall  out  1  hold IF..EX/MEM registers
- memwb_write_data  out  DATA_W  writeback value
- memwb_write_reg  out  REG_W  writeback index
- memwb_reg_write  out  1  writeback enable
- memwb_mem_to_reg  out  1  forwarded control
- misalign_err  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, reset==0): state IDLE, timeout counter 0; every output, including dmem_* and memwb_*, is 0. Reset mid-transaction drops dmem_req immediately; the transaction is abandoned.
- access = mem_read | mem_write. If both are set, write wins (dmem_we=1).
- aligned = (exmem_alu_result[1:0] == 0).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access & aligned: mem_stall=1 (combinational). Next clock → BUSY; register dmem_req=1, dmem_we, dmem_addr, dmem_wdata.
  - access & !aligned: no request, mem_stall=0. MEM/WB loads with reg_write=0; misalign_err=1 for next cycle.
  - no access: mem_stall=0; MEM/WB loads normally every cycle.
- BUSY:
  - mem_stall=1; dmem_* held stable; counter increments each cycle.
  - dmem_ack: capture dmem_rdata, drop dmem_req, → DONE.
  - counter reaches TIMEOUT with no ack: drop dmem_req, set abort flag, → DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - mem_stall=0; clear counter; MEM/WB loads at this edge; → IDLE.
  - On abort: memwb_reg_write=0 and bus_err=1 for next cycle.
- Minimum load/store latency: 3 cycles (IDLE detect, BUSY with ack, DONE). Each extra wait cycle adds one.
- MEM/WB load value: write_data = jal ? exmem_pc : mem_to_reg ? captured_rdata : exmem_alu_result.
- While mem_stall=1, MEM/WB loads a bubble: reg_write=0, other fields hold, so no double writeback.
- dmem_ack outside BUSY is ignored.
- Upstream contract: EX/MEM inputs are stable whenever mem_stall=1.

Decomposition:
- Package mips_mem_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - DATA_W and REG_W defaults
  - WORD_ALIGN_MASK = 2'b11
  - counter width = $clog2(TIMEOUT+1)
- One natural sub-module: mem_wb_register. It provides async active-low reset, load enable, and bubble insertion, and holds write_data, write_reg, reg_write and mem_to_reg.
- The FSM, counter and dmem interface stay in the top level.

Test Plan:
- Reset asserted mid-BUSY (dmem_req=1) → dmem_req and all outputs read 0 in the same cycle; state IDLE after release.
- Load: alu_result=0x100, mem_read=1, mem_to_reg=1, write_reg=8; ack on first BUSY cycle, rdata=0xDEADBEEF → mem_stall high for exactly 2 cycles; memwb_write_data=0xDEADBEEF, write_reg=8, reg_write=1.
- Store with 3 wait cycles: addr=0x200, wdata=0x12345678 → dmem_addr, dmem_wdata and dmem_we=1 stable for all 4 BUSY cycles; stall held 5 cycles; memwb_reg_write=0 (reg_write input 0).
- Misaligned load at 0x102 → no dmem_req, no stall; misalign_err pulses 1 cycle; memwb_reg_write=0.
- TIMEOUT=4, no ack → dmem_req high 4 cycles then drops; bus_err pulses; writeback squashed.
- ALU op (reg_write=1, alu_result=7), then jal (pc=0x40), back-to-back with no access → memwb_write_data 7 then 0x40 on consecutive cycles; mem_stall never asserts.
